// File: rtl/writeback_unit.sv
// writeback_unit: last stage of the rvsimple datapath. It retires one
// instruction per handshake, picks the result source, waits for load data,
// formats sub-word loads and drives the register-file write port. It also
// counts retired instructions.
//
// Handshake: an instruction transfers on a rising clock edge where
// in_valid && in_ready. in_ready depends only on the FSM state. The upstream
// stage must hold its fields stable while in_valid is high and in_ready is
// low. mem_rsp_valid has no ready: a response is consumed on the edge where
// it is seen in WAIT_LOAD and is ignored in IDLE.
module writeback_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd_address,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_csr_data,
  input  logic [2:0]  in_funct3,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        write_enable,
  output logic [4:0]  rd_address,
  output logic [31:0] rd_data,
  output logic        load_pending,
  output logic [63:0] instret
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_CSR  = 2'd3;

  state_t      state;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_offset;
  logic [31:0] sel_data;
  logic [31:0] load_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        accept;

  assign in_ready     = (state == IDLE);
  assign load_pending = (state == WAIT_LOAD);
  assign accept       = in_valid && in_ready;

  // Result source for non-load instructions.
  always_comb begin
    sel_data = in_alu_result;
    case (in_wb_sel)
      WB_ALU:  sel_data = in_alu_result;
      WB_PC4:  sel_data = in_pc_plus4;
      WB_CSR:  sel_data = in_csr_data;
      default: sel_data = in_alu_result;
    endcase
  end

  // Lane select and extension of the raw memory word using the latched
  // address offset; the half-word lane ignores offset bit 0.
  always_comb begin
    byte_lane = mem_rsp_data[7:0];
    case (load_offset)
      2'd0: byte_lane = mem_rsp_data[7:0];
      2'd1: byte_lane = mem_rsp_data[15:8];
      2'd2: byte_lane = mem_rsp_data[23:16];
      2'd3: byte_lane = mem_rsp_data[31:24];
      default: byte_lane = mem_rsp_data[7:0];
    endcase
    half_lane = load_offset[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    load_data = mem_rsp_data;
    case (load_funct3)
      3'd0: load_data = {{24{byte_lane[7]}}, byte_lane};
      3'd1: load_data = {{16{half_lane[15]}}, half_lane};
      3'd4: load_data = {24'd0, byte_lane};
      3'd5: load_data = {16'd0, half_lane};
      default: load_data = mem_rsp_data;
    endcase
  end

  // FSM, registered write port and retire counter. write_enable is a
  // one-cycle pulse; rd_address/rd_data hold between writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      write_enable <= 1'b0;
      rd_address   <= 5'd0;
      rd_data      <= 32'd0;
      instret      <= 64'd0;
      load_rd      <= 5'd0;
      load_funct3  <= 3'd0;
      load_offset  <= 2'd0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_wb_sel == WB_LOAD) begin
              load_rd     <= in_rd_address;
              load_funct3 <= in_funct3;
              load_offset <= in_alu_result[1:0];
              state       <= WAIT_LOAD;
            end else begin
              rd_address   <= in_rd_address;
              rd_data      <= sel_data;
              write_enable <= (in_rd_address != 5'd0);
              instret      <= instret + 64'd1;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rsp_valid) begin
            rd_address   <= load_rd;
            rd_data      <= load_data;
            write_enable <= (load_rd != 5'd0);
            instret      <= instret + 64'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
